top_psw: RTL and testbench
==========================

# top_psw

Four-digit password lock for a DE10-Lite-style board. Ten slide switches act as digit keys 0–9. The block debounces them and detects key presses, then checks the entered sequence against the fixed password 2-0-1-6 in an FSM. The result appears on five active-low seven-segment displays. It is the top level of the password lab.

## Interface
- No parameters at top level; password and debounce length are package/sub-module constants.
- `clk` in 1: single system clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `sw` in 10: slide switches; `sw[k]` high means digit k is pressed.
- `HEX4`..`HEX0` out 7 each: active-low segments, bit order {g,f,e,d,c,b,a}.

## Operation
- `sw` passes through a `debouncer` instance (ports `clk`, `rst_n`, `sw[9:0]`, `sw_clean[9:0]`). It is instantiated with no parameter overrides. Top-level logic must not depend on debouncer latency.
- Press event: `sw_clean != 0` while registered previous `sw_clean == 0`. Only one event per press; holding or adding switches produces nothing until all return to 0.
- Entered digit is valid only if `sw_clean` is one-hot. A non-one-hot press counts as a wrong digit.
- FSM instance is named `fsm_inst`. Its 3-bit state register is named `state`:
  - IDLE=0: correct digit 2 → GOT1; any other press → ERROR.
  - GOT1=1: digit 0 → GOT2; else → ERROR.
  - GOT2=2: digit 1 → GOT3; else → ERROR.
  - GOT3=3: digit 6 → OPEN; else → ERROR.
  - OPEN=4 and ERROR=5: hold. The next press event is consumed (not treated as a digit) → IDLE.
  - Codes 6–7 unreachable → IDLE on next clock.
- Display is decoded combinationally from `state`:
  - IDLE: all HEX blank (1111111).
  - GOT1: HEX3 = '-' (0111111), others blank.
  - GOT2: HEX3 and HEX2 = '-', others blank.
  - GOT3: HEX3, HEX2 and HEX1 = '-', others blank.
  - OPEN: HEX4..HEX1 = O(1000000), P(0001100), E(0000110), n(0101011); HEX0 blank.
  - ERROR: HEX4..HEX0 = E(0000110), r(0101111), r, o(0100011), r.

## Timing
- Reset sampled on `posedge clk` while `rst_n`=0: `state`=IDLE, previous-switch register = 0, all HEX blank.
- Reset mid-entry or in OPEN/ERROR returns to IDLE on that edge and clears partial entry.
- With a pass-through debouncer: `sw` applied after edge N → `state` updates at edge N+1. HEX follows in the same cycle (no extra register).
- One-cycle press pulses are sufficient; 1-cycle release between presses is sufficient.
- A switch already high when reset releases produces no event until it drops to 0 and rises again.
- Simultaneous multi-bit press counts as one wrong-digit event.

## Structure
- Package `psw_pkg` holds:
  - state encodings IDLE..ERROR (3-bit);
  - `PSW_DIGITS` = {2,0,1,6};
  - segment constants BLANK, DASH, O, P, E, n, r, o.
- Sub-modules:
  - `debouncer`: counter-based, internal default parameter for about 10 ms at 50 MHz.
  - `psw_fsm` (instance `fsm_inst`): edge detect, one-hot check, state register.
- Seven-segment decode lives in `top_psw`.

## Test plan
- Reset 2 cycles, then `rst_n`=1 → `state`=0, all HEX = 1111111.
- Press sequence 0x004, 0x001, 0x002, 0x040, each 1 cycle with 0 between → state 1, 2, 3, 4. HEX after final press: 1000000, 0001100, 0000110, 0101011, 1111111.
- From IDLE, press 0x008 → state 5; HEX reads E r r o r. A following press of 0x001 → state 0, not GOT1.
- Press 0x004 then 0x005 (two bits) → state 1 then 5.
- Hold 0x004 for 5 cycles → single transition to 1; state stays 1.
- Assert `rst_n`=0 while in state 3 → state 0 at next edge, all HEX blank.

Source files
------------

// File: rtl/psw_pkg.sv
// Shared constants for the 2-0-1-6 password lock: state codes, password digits
// and active-low seven-segment patterns ({g,f,e,d,c,b,a}).
package psw_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GOT1  = 3'd1,
    GOT2  = 3'd2,
    GOT3  = 3'd3,
    OPEN  = 3'd4,
    ERROR = 3'd5
  } psw_state_t;

  localparam logic [3:0] PSW_DIGITS [4] = '{4'd2, 4'd0, 4'd1, 4'd6};

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] O     = 7'b1000000;
  localparam logic [6:0] P     = 7'b0001100;
  localparam logic [6:0] E     = 7'b0000110;
  localparam logic [6:0] n     = 7'b0101011;
  localparam logic [6:0] r     = 7'b0101111;
  localparam logic [6:0] o     = 7'b0100011;

  // Index of the highest set key; only meaningful when the key vector is one-hot.
  function automatic logic [3:0] key_index(input logic [9:0] keys);
    key_index = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (keys[i]) key_index = 4'(i);
    end
  endfunction

endpackage

// File: rtl/debouncer.sv
// Switch debouncer: synchronises the switches and only passes a new pattern
// once it has been stable for DEBOUNCE_CYCLES clocks (about 10 ms at 50 MHz).
module debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] sw,
  output logic [9:0] sw_clean
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

  logic [9:0]    sync_0, sync_1, sw_last;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_0   <= '0;
      sync_1   <= '0;
      sw_last  <= '0;
      cnt      <= '0;
      sw_clean <= '0;
    end else begin
      sync_0 <= sw;
      sync_1 <= sync_0;
      if (sync_1 != sw_last) begin
        sw_last <= sync_1;
        cnt     <= '0;
      end else if (cnt != CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt <= cnt + 1'b1;
      end else begin
        sw_clean <= sw_last;
      end
    end
  end

endmodule

// File: rtl/psw_fsm.sv
// Press detection, one-hot digit check and the password state register.
module psw_fsm
  import psw_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] sw_clean,
  output psw_state_t state
);

  psw_state_t state_next;
  logic [9:0] sw_prev;
  logic       armed;
  logic       press;
  logic       key_ok;
  logic [3:0] key;

  // armed stays low until all switches have been seen released after reset,
  // so a switch held through reset cannot create an event.
  assign press  = (sw_clean != '0) && (sw_prev == '0) && armed;
  assign key_ok = $onehot(sw_clean);
  assign key    = key_index(sw_clean);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      sw_prev <= '0;
      armed   <= 1'b0;
    end else begin
      state   <= state_next;
      sw_prev <= sw_clean;
      if (sw_clean == '0) armed <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:        if (press) state_next = (key_ok && key == PSW_DIGITS[0]) ? GOT1 : ERROR;
      GOT1:        if (press) state_next = (key_ok && key == PSW_DIGITS[1]) ? GOT2 : ERROR;
      GOT2:        if (press) state_next = (key_ok && key == PSW_DIGITS[2]) ? GOT3 : ERROR;
      GOT3:        if (press) state_next = (key_ok && key == PSW_DIGITS[3]) ? OPEN : ERROR;
      OPEN, ERROR: if (press) state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/top_psw.sv
// Password lock top level: debounced switches feed the FSM, whose state is
// decoded straight onto the five active-low seven-segment displays.
module top_psw
  import psw_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] sw,
  output logic [6:0] HEX4,
  output logic [6:0] HEX3,
  output logic [6:0] HEX2,
  output logic [6:0] HEX1,
  output logic [6:0] HEX0
);

  logic [9:0] sw_clean;
  psw_state_t state;

  debouncer u_debouncer (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw       (sw),
    .sw_clean (sw_clean)
  );

  psw_fsm fsm_inst (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw_clean (sw_clean),
    .state    (state)
  );

  always_comb begin
    HEX4 = BLANK;
    HEX3 = BLANK;
    HEX2 = BLANK;
    HEX1 = BLANK;
    HEX0 = BLANK;
    case (state)
      GOT1: HEX3 = DASH;
      GOT2: begin HEX3 = DASH; HEX2 = DASH; end
      GOT3: begin HEX3 = DASH; HEX2 = DASH; HEX1 = DASH; end
      OPEN: begin HEX4 = O; HEX3 = P; HEX2 = E; HEX1 = n; end
      ERROR: begin HEX4 = E; HEX3 = r; HEX2 = r; HEX1 = o; HEX0 = r; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_top_psw.sv
// Self-checking bench for top_psw; the debouncer output is overridden so the
// lock logic sees switch changes on the next clock.
module tb_top_psw;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] sw;
  logic [9:0] sw_force;
  logic [6:0] HEX4, HEX3, HEX2, HEX1, HEX0;

  int tests = 0;
  int fails = 0;

  int m_state;
  bit m_zero_seen;
  int pw [4] = '{2, 0, 1, 6};

  top_psw dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw),
    .HEX4  (HEX4),
    .HEX3  (HEX3),
    .HEX2  (HEX2),
    .HEX1  (HEX1),
    .HEX0  (HEX0)
  );

  always #5 clk = ~clk;

  // States 0..3 count correct digits so far, 4 = open, 5 = error.
  function automatic int next_state(input int s, input logic [9:0] v);
    logic [9:0] want;
    if (s >= 4) return 0;
    want = 10'd1 << pw[s];
    if ($countones(v) == 1 && v == want) return s + 1;
    return 5;
  endfunction

  function automatic logic [34:0] exp_hex(input int s);
    logic [6:0] bl, da;
    bl = 7'h7F;
    da = 7'h3F;
    case (s)
      1:       return {bl, da, bl, bl, bl};
      2:       return {bl, da, da, bl, bl};
      3:       return {bl, da, da, da, bl};
      4:       return {7'b1000000, 7'b0001100, 7'b0000110, 7'b0101011, bl};
      5:       return {7'b0000110, 7'b0101111, 7'b0101111, 7'b0100011, 7'b0101111};
      default: return {bl, bl, bl, bl, bl};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [9:0] v);
    sw       = v;
    sw_force = v;
    force dut.sw_clean = sw_force;
    @(posedge clk);
    if (!rst_n) begin
      m_state     = 0;
      m_zero_seen = 1'b0;
    end else begin
      if (v != '0 && m_zero_seen) m_state = next_state(m_state, v);
      m_zero_seen = (v == '0);
    end
    #1;
    chk({tag, ".state"}, 35'(dut.fsm_inst.state), 35'(m_state));
    chk({tag, ".hex"}, {HEX4, HEX3, HEX2, HEX1, HEX0}, exp_hex(m_state));
  endtask

  initial begin
    logic [9:0] v;
    logic [9:0] last;
    int         sel;

    rst_n    = 1'b0;
    sw       = '0;
    sw_force = '0;
    force dut.sw_clean = sw_force;
    @(negedge clk);

    step("reset0", 10'h000);
    step("reset1", 10'h000);
    rst_n = 1'b1;
    step("idle", 10'h000);

    step("d2", 10'h004);  step("rel", 10'h000);
    step("d0", 10'h001);  step("rel", 10'h000);
    step("d1", 10'h002);  step("rel", 10'h000);
    step("d6", 10'h040);  step("rel", 10'h000);
    step("open_consume", 10'h008); step("rel", 10'h000);

    step("wrong_first", 10'h008); step("rel", 10'h000);
    step("err_consume", 10'h001); step("rel", 10'h000);

    step("d2b", 10'h004);   step("rel", 10'h000);
    step("multibit", 10'h005); step("rel", 10'h000);
    step("err_consume2", 10'h001); step("rel", 10'h000);

    for (int i = 0; i < 5; i++) step("hold", 10'h004);
    step("add_key", 10'h006);
    step("rel", 10'h000);
    step("d0b", 10'h001); step("rel", 10'h000);
    step("d1b", 10'h002); step("rel", 10'h000);
    rst_n = 1'b0;
    step("mid_reset", 10'h000);
    rst_n = 1'b1;
    step("after_reset", 10'h000);

    rst_n = 1'b0;
    step("held_reset", 10'h004);
    rst_n = 1'b1;
    step("held_after", 10'h004);
    step("held_after2", 10'h004);
    step("held_rel", 10'h000);
    step("held_repress", 10'h004);
    step("rel", 10'h000);

    last = '0;
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1, 2, 3, 4: v = '0;
        5, 6:          v = 10'd1 << pw[(m_state < 4) ? m_state : 0];
        7:             v = 10'd1 << $urandom_range(0, 9);
        8:             v = 10'($urandom);
        default:       v = last;
      endcase
      rst_n = ($urandom_range(0, 59) != 0);
      step("rand", v);
      last = v;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
